// File: rtl/mem_responder.sv
// Word-array memory responder: one request at a time over valid/ready,
// response returned LATENCY cycles after acceptance and held until taken.
module mem_responder #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH_LOG2 = 10,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h8000_0000,
  parameter int                    LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wen,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [3:0]            req_wmask,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err
);

  localparam int WORDS = 1 << DEPTH_LOG2;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_resp_valid;
  logic                  r_resp_err;
  logic [DATA_WIDTH-1:0] r_resp_rdata;
  logic [DATA_WIDTH-1:0] r_mem [WORDS];

  logic                  w_accept;
  logic                  w_in_range;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic [DATA_WIDTH-1:0] w_word;
  logic [DATA_WIDTH-1:0] w_rd_shifted;

  // req_ready also drops combinationally with rst so it reads 0 during reset
  // and 1 in the very first cycle after release.
  assign req_ready    = (r_state == IDLE) && !rst;
  assign w_accept     = req_valid && req_ready;
  assign w_in_range   = (req_addr[ADDR_WIDTH-1:DEPTH_LOG2+2] ==
                         BASE_ADDR[ADDR_WIDTH-1:DEPTH_LOG2+2]);
  assign w_idx        = req_addr[DEPTH_LOG2+1:2];
  assign w_word       = r_mem[w_idx];
  assign w_rd_shifted = w_word >> {req_addr[1:0], 3'b000};

  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_cnt        <= CNT_LOAD;
            r_resp_err   <= !w_in_range;
            r_resp_rdata <= (w_in_range && !req_wen) ? w_rd_shifted : '0;
            if (LATENCY > 1) begin
              r_state <= WAIT;
            end else begin
              r_state      <= RESP;
              r_resp_valid <= 1'b1;
            end
          end
        end
        // Counter holds the WAIT cycles still to run including this one, so
        // leaving at 1 puts resp_valid exactly LATENCY cycles after acceptance.
        WAIT: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) begin
            r_state      <= RESP;
            r_resp_valid <= 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            r_state      <= IDLE;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // The array has no reset: committed writes survive a reset.
  always_ff @(posedge clk) begin
    if (w_accept && req_wen && w_in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (req_wmask[i]) r_mem[w_idx][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

endmodule
